// File: rtl/jtgng_linebuf_rd_pkg.sv
// Shared constants for the line-buffer read engine: FSM encodings and default blank colour.
// The erase write-back is built only when JTGNG_LINEBUF_ERASE_EN is defined (off by default).
package jtgng_linebuf_rd_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_PRIME = 2'd1;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd2;

  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_AW = 8;

  localparam logic [DEF_DW-1:0] DEF_BLANK_VAL = {DEF_DW{1'b1}};

endpackage

// File: rtl/jtgng_linebuf_rd_if.sv
// RAM-side bus of the line-buffer reader: read port plus erase write-back port.
interface jtgng_linebuf_rd_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] erase_addr;
  logic [DW-1:0] erase_data;
  logic          erase_we;

  modport master (
    output ram_addr,
    input  ram_q,
    output erase_addr,
    output erase_data,
    output erase_we
  );

  modport slave (
    input  ram_addr,
    output ram_q,
    input  erase_addr,
    input  erase_data,
    input  erase_we
  );

endinterface

// File: rtl/jtgng_linebuf_rd.sv
// Line-buffer scan-out: walks the RAM read port for LINE_LEN pixels per line, hiding the
// one-clock read latency. Define JTGNG_LINEBUF_ERASE_EN to blank each location after reading.
module jtgng_linebuf_rd
  import jtgng_linebuf_rd_pkg::*;
#(
  parameter int unsigned   DW        = 8,
  parameter int unsigned   AW        = 8,
  parameter int unsigned   LINE_LEN  = 256,
  parameter logic [DW-1:0] BLANK_VAL = {DW{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 line_start,
  input  logic [AW-1:0]        start_addr,
  jtgng_linebuf_rd_if.master   ram,
  output logic [DW-1:0]        pxl,
  output logic                 pxl_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned     CW   = $clog2(LINE_LEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(LINE_LEN - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]   pxl_q,   pxl_d;
  logic            valid_q, valid_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pxl_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pxl_q   <= pxl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; nothing moves between cen edges.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pxl_d   = pxl_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (cen) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
        end
        ST_PRIME: begin
          valid_d = 1'b0;
          addr_d  = addr_q + AW'(1);
          state_d = ST_RUN;
        end
        ST_RUN: begin
          pxl_d   = ram.ram_q;
          valid_d = 1'b1;
          addr_d  = addr_q + AW'(1);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
      // A restart aborts the line, except that a final pixel on the same cen is still emitted.
      if (line_start) begin
        state_d = ST_PRIME;
        addr_d  = start_addr;
        cnt_d   = '0;
        if (!(state_q == ST_RUN && cnt_q == LAST)) begin
          valid_d = 1'b0;
          pxl_d   = pxl_q;
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign ram.ram_addr   = addr_q;
  assign ram.erase_data = BLANK_VAL;

`ifdef JTGNG_LINEBUF_ERASE_EN
  // The location captured this cen sits one behind the read address.
  assign ram.erase_we   = cen & (state_q == ST_RUN);
  assign ram.erase_addr = addr_q - AW'(1);
`else
  assign ram.erase_we   = 1'b0;
  assign ram.erase_addr = '0;
`endif

  assign pxl       = pxl_q;
  assign pxl_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jtgng_linebuf_rd.sv
// Directed bench for jtgng_linebuf_rd with a behavioural registered-read RAM (LINE_LEN=16).
module tb_jtgng_linebuf_rd;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned LL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          line_start;
  logic [AW-1:0] start_addr;
  logic [DW-1:0] pxl;
  logic          pxl_valid;
  logic          busy;
  logic          done;
  logic          load;
  logic          we_seen;

  int total = 0;
  int bad   = 0;
  int div   = 1;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  jtgng_linebuf_rd_if #(.DW(DW), .AW(AW)) ram_if ();

  jtgng_linebuf_rd #(.DW(DW), .AW(AW), .LINE_LEN(LL), .BLANK_VAL(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .line_start (line_start),
    .start_addr (start_addr),
    .ram        (ram_if.master),
    .pxl        (pxl),
    .pxl_valid  (pxl_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // RAM model: clk_en tied to cen, one-clock registered read, write port for erase.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (cen) begin
      ram_if.ram_q <= mem[ram_if.ram_addr];
      if (ram_if.erase_we) mem[ram_if.erase_addr] <= ram_if.erase_data;
    end
  end

  always @(posedge clk) if (ram_if.erase_we === 1'b1) we_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cen edge; on slow cen the gap clocks must leave the outputs untouched.
  task automatic cen_cycle();
    logic [DW-1:0] p;
    logic          v;
    p = pxl;
    v = pxl_valid;
    for (int g = 1; g < div; g++) begin
      cen = 1'b0;
      @(posedge clk); #1;
      chk("hold_pxl", 32'(pxl), 32'(p));
      chk("hold_valid", 32'(pxl_valid), 32'(v));
    end
    cen = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_line(input logic [7:0] start, input int n, input bit skip_start,
                          input bit restart, input logic [7:0] nxt);
    logic [7:0] a;
    if (!skip_start) begin
      line_start = 1'b1;
      start_addr = start;
      cen_cycle();
      line_start = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_valid", 32'(pxl_valid), 32'd0);
      chk("accept_done", 32'(done), 32'd0);
      chk("accept_addr", 32'(ram_if.ram_addr), 32'(start));
    end
    cen_cycle();
    chk("prime_valid", 32'(pxl_valid), 32'd0);
    chk("prime_addr", 32'(ram_if.ram_addr), 32'(8'(start + 8'd1)));
    for (int i = 0; i < n; i++) begin
      a = 8'(start + 8'(i));
      if (restart && i == int'(LL) - 1) begin
        line_start = 1'b1;
        start_addr = nxt;
      end
      cen_cycle();
      line_start = 1'b0;
      chk("run_pxl", 32'(pxl), 32'(ref_mem[a]));
      chk("run_valid", 32'(pxl_valid), 32'd1);
      chk("run_done", 32'(done), (i == int'(LL) - 1) ? 32'd1 : 32'd0);
      chk("run_busy", 32'(busy), (i == int'(LL) - 1 && !restart) ? 32'd0 : 32'd1);
`ifdef JTGNG_LINEBUF_ERASE_EN
      ref_mem[a] = 8'hFF;
`endif
    end
    if (restart) begin
      chk("restart_addr", 32'(ram_if.ram_addr), 32'(nxt));
    end else if (n == int'(LL)) begin
      cen_cycle();
      chk("tail_valid", 32'(pxl_valid), 32'd0);
      chk("tail_done", 32'(done), 32'd0);
      chk("tail_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(ram_if.ram_addr), 32'd0);
    chk({tag, "_pxl"}, 32'(pxl), 32'd0);
    chk({tag, "_valid"}, 32'(pxl_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b1;
    cen        = 1'b1;
    line_start = 1'b0;
    start_addr = '0;
    we_seen    = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_we", 32'(ram_if.erase_we), 32'd0);
    load  = 1'b0;
    rst_n = 1'b1;
    cen   = 1'b0;
    @(posedge clk); #1;

    // Basic line from 0x00, cen every clk.
    run_line(8'h00, LL, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
`ifdef JTGNG_LINEBUF_ERASE_EN
      chk("erase_mem", 32'(mem[i]), 32'hFF);
`else
      chk("keep_mem", 32'(mem[i]), 32'(8'(i)));
`endif
    end
    chk("mem_0x10", 32'(mem[16]), 32'h10);

    // Address wrap across 0xFF -> 0x00.
    run_line(8'hF8, LL, 1'b0, 1'b0, 8'h00);

    // cen one clk in three.
    div = 3;
    run_line(8'h30, LL, 1'b0, 1'b0, 8'h00);
    div = 1;

    // Abort at pixel 5 and restart from 0x80; the abort cen still erases 0x25.
    run_line(8'h20, 5, 1'b0, 1'b0, 8'h00);
`ifdef JTGNG_LINEBUF_ERASE_EN
    ref_mem[8'h25] = 8'hFF;
`endif
    run_line(8'h80, LL, 1'b0, 1'b0, 8'h00);
    chk("mem_0x26", 32'(mem[8'h26]), 32'h26);

    // Restart on the final pixel: done still pulses, then the new line runs.
    run_line(8'h50, LL, 1'b0, 1'b1, 8'h60);
    run_line(8'h60, LL, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset between clk edges in the middle of a line.
    run_line(8'h40, 3, 1'b0, 1'b0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_we", 32'(ram_if.erase_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cen_cycle();
      chk_reset_outputs("idle");
    end
    chk("mem_0x43", 32'(mem[8'h43]), 32'h43);
`ifdef JTGNG_LINEBUF_ERASE_EN
    chk("mem_0x42", 32'(mem[8'h42]), 32'hFF);
`else
    chk("mem_0x42", 32'(mem[8'h42]), 32'h42);
    chk("we_never", 32'(we_seen), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
